// File: rtl/shift_unit_seq.sv
// ---------------------------------------------------------------------------
// shift_unit_seq
//   Multi-cycle shifter shared by ALU-side blocks. A request is latched on a
//   valid/ready accept. The working register is then shifted by at most STEP
//   bits per cycle until the full shift amount has been applied, and the
//   result is presented on a valid/ready output port.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
//   valid && ready are both high. A producer holds its valid and data stable
//   until that transfer. in_ready is high only in IDLE. The unit holds
//   out_valid and B stable until the consumer takes the result.
//
// Optional feature macro: SHIFT_UNIT_ROTATE_EN
//   defined   : MODE 11 rotates left (ROL)
//   undefined : MODE 11 behaves as SLL and no rotate wrap logic is built
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   request valid
//   in_ready   unit can accept a request (IDLE and out of reset)
//   A          operand, N bits
//   SHAMT      shift amount 0..N-1
//   MODE       00 SLL, 01 SRL, 10 SRA, 11 ROL/SLL
//   out_valid  result valid (DONE state)
//   out_ready  consumer accepts result
//   B          result; keeps its last value after it is consumed
//   busy       high while in SHIFT or DONE
//   state_dbg  current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
// ---------------------------------------------------------------------------
module shift_unit_seq #(
  parameter int N    = 32,
  parameter int STEP = 4,
  localparam int SW  = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  A,
  input  logic [SW-1:0] SHAMT,
  input  logic [1:0]    MODE,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  B,
  output logic          busy,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SW:0]  STEP_W = (SW+1)'(STEP);
  localparam logic [SW:0]  N_W    = (SW+1)'(N);
  localparam logic [N-1:0] ONES   = '1;

  state_t        state, state_next;
  logic          alive;
  logic [N-1:0]  work, work_next;
  logic [N-1:0]  b_q;
  logic [SW-1:0] rem, rem_next;
  logic [1:0]    mode_q;
  logic          sign_q;
  logic          load_b;
  logic          accept;
  logic [SW:0]   k;
  logic [N-1:0]  stepped;

  // alive keeps in_ready low until the first clock edge after reset releases.
  assign in_ready  = alive && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign B         = b_q;
  assign state_dbg = state;
  assign accept    = in_valid && in_ready;

  // One shift step: k = min(STEP, remaining).
  always_comb begin
    k = ({1'b0, rem} > STEP_W) ? STEP_W : {1'b0, rem};
    case (mode_q)
      2'b01:   stepped = work >> k;
      // SRA fills from the sign bit captured at accept, not the current MSB.
      2'b10:   stepped = (work >> k) | (sign_q ? ~(ONES >> k) : '0);
`ifdef SHIFT_UNIT_ROTATE_EN
      // k is never 0 in SHIFT, so N-k stays below N.
      2'b11:   stepped = (work << k) | (work >> (N_W - k));
`endif
      default: stepped = work << k;
    endcase
  end

  always_comb begin
    state_next = state;
    work_next  = work;
    rem_next   = rem;
    load_b     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          work_next = A;
          rem_next  = SHAMT;
          if (SHAMT != '0) begin
            state_next = SHIFT;
          end else begin
            state_next = DONE;
            load_b     = 1'b1;
          end
        end
      end
      SHIFT: begin
        work_next = stepped;
        rem_next  = rem - k[SW-1:0];
        if ({1'b0, rem} == k) begin
          state_next = DONE;
          load_b     = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      alive  <= 1'b0;
      work   <= '0;
      b_q    <= '0;
      rem    <= '0;
      mode_q <= 2'b00;
      sign_q <= 1'b0;
    end else begin
      state <= state_next;
      alive <= 1'b1;
      work  <= work_next;
      rem   <= rem_next;
      if (load_b) b_q <= work_next;
      if (accept) begin
        mode_q <= MODE;
        sign_q <= A[N-1];
      end
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// ---------------------------------------------------------------------------
// tb_shift_unit_seq
//   Directed and randomized requests against shift_unit_seq (N=32, STEP=4).
//   Expected results come from a plain-arithmetic reference shift; latency,
//   backpressure and mid-operation reset behaviour are checked as well.
// ---------------------------------------------------------------------------
module tb_shift_unit_seq;

  localparam int N    = 32;
  localparam int STEP = 4;
  localparam int SW   = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  A = '0;
  logic [SW-1:0] SHAMT = '0;
  logic [1:0]    MODE = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  B;
  logic          busy;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  shift_unit_seq #(.N(N), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .SHAMT(SHAMT), .MODE(MODE), .out_valid(out_valid),
    .out_ready(out_ready), .B(B), .busy(busy), .state_dbg(state_dbg)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- check helper ----
  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---- reference model: one shift by the whole amount ----
  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] a, input int sh,
                                             input logic [1:0] mode);
    logic [N-1:0] r;
    case (mode)
      2'b00: r = a << sh;
      2'b01: r = a >> sh;
      2'b10: r = $signed(a) >>> sh;
      default: begin
`ifdef SHIFT_UNIT_ROTATE_EN
        r = (sh == 0) ? a : ((a << sh) | (a >> (N - sh)));
`else
        r = a << sh;
`endif
      end
    endcase
    return r;
  endfunction

  // ---- driver: one full request/response, called at a negedge ----
  task automatic run_req(input logic [N-1:0] a, input int sh, input logic [1:0] mode,
                         input int hold, input string tag);
    int cyc;
    logic [N-1:0] exp_b;
    logic [N-1:0] held_b;
    exp_q.push_back(ref_shift(a, sh, mode));
    in_valid = 1'b1;
    A        = a;
    SHAMT    = SW'(sh);
    MODE     = mode;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_accept_ready"}, in_ready, 1'b1);
    @(posedge clk);  // accept edge
    @(negedge clk);
    in_valid = 1'b0;
    A        = $urandom;
    SHAMT    = SW'($urandom);
    MODE     = 2'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      check({tag, "_busy"}, busy, 1'b1);
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, 1 + (sh + STEP - 1) / STEP);
    exp_b = exp_q.pop_front();
    check({tag, "_result"}, B, exp_b);
    check({tag, "_in_ready_low"}, in_ready, 1'b0);
    held_b = B;
    // Backpressure: result must hold; a competing request is ignored.
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      A        = $urandom;
      SHAMT    = SW'($urandom);
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_b"}, B, held_b);
      check({tag, "_hold_in_ready"}, in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drop_valid"}, out_valid, 1'b0);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_ready"}, in_ready, 1'b1);
    check({tag, "_b_kept"}, B, held_b);
  endtask

  // ---- stimulus ----
  initial begin
    logic [N-1:0] rot_exp;
    int seen;
    int sh;

    // Reset state
    #2;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_b", B, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_ready", in_ready, 1'b0);
    @(negedge clk);
    check("first_edge_ready", in_ready, 1'b1);

    // Directed cases
    run_req(32'd45, 3, 2'b00, 0, "sll3");
    check("sll3_value", B, 32'h168);
    run_req(32'd290, 0, 2'b01, 0, "srl0");
    check("srl0_value", B, 32'd290);
    run_req(32'hFFFF_FFFF, 31, 2'b01, 0, "srl31");
    check("srl31_value", B, 32'h1);
    run_req(32'h8000_0000, 4, 2'b10, 0, "sra4");
    check("sra4_value", B, 32'hF800_0000);
    run_req(32'h4000_0000, 5, 2'b10, 0, "sra5");
    check("sra5_value", B, 32'h0200_0000);
`ifdef SHIFT_UNIT_ROTATE_EN
    rot_exp = 32'h3;
`else
    rot_exp = 32'h2;
`endif
    run_req(32'h8000_0001, 1, 2'b11, 0, "rol1");
    check("rol1_value", B, rot_exp);
    run_req(32'h8765_4321, 13, 2'b11, 0, "rol13");
    run_req(32'hDEAD_BEEF, 7, 2'b10, 5, "backpressure");

    // Reset in the middle of a shift
    in_valid = 1'b1;
    A        = 32'h0000_FFFF;
    SHAMT    = SW'(20);
    MODE     = 2'b00;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_b", B, '0);
    check("midrst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_pulse", seen, 0);
    run_req(32'h0000_FFFF, 20, 2'b00, 1, "after_rst");
    check("after_rst_value", B, 32'hFFF0_0000);

    // Randomized requests
    for (int i = 0; i < 40; i++) begin
      sh = (i % 8 == 0) ? 0 : ((i % 8 == 1) ? N - 1 : $urandom_range(0, N - 1));
      run_req($urandom, sh, 2'($urandom_range(0, 3)), $urandom_range(0, 3), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends with a summary line.
  initial begin
    #200000;
    checks++;
    errors++;
    $display("FAIL global_timeout: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
